// File: rtl/jedro_1_lsu.sv
// jedro_1_lsu - load-store unit for the jedro_1 core.
//
// Runs one load or store at a time over the core data interface
// (req/gnt/rvalid handshake). Accepts an op from the control FSM,
// checks alignment, drives byte enables and lane-replicated write data,
// holds the request until granted, then waits for the response and
// writes sign/zero-extended load data back to the register file.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   ctrl_*                 op handshake from the control FSM, plus
//                          done/misalign/err pulses and faulting address
//   rf_*                   register-file write port (load writeback)
//   data_*                 core data bus (req/gnt/rvalid protocol)
//
// All outputs are registered.
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  output logic                      ctrl_ready_o,
  input  logic                      ctrl_we_i,
  input  logic [1:0]                ctrl_size_i,
  input  logic                      ctrl_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]     ctrl_addr_i,
  input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] ctrl_rd_i,
  output logic                      ctrl_done_o,
  output logic                      ctrl_misalign_o,
  output logic                      ctrl_err_o,
  output logic [ADDR_WIDTH-1:0]     ctrl_bad_addr_o,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_data_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [ADDR_WIDTH-1:0]     data_addr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_err_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]                state;
  logic [1:0]                size_q;
  logic                      unsigned_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic                  legal;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  // Alignment check, byte enables and lane replication for the offered op.
  always_comb begin
    legal      = 1'b0;
    be_next    = 4'b0000;
    wdata_next = ctrl_wdata_i;
    case (ctrl_size_i)
      SZ_BYTE: begin
        legal      = 1'b1;
        be_next    = 4'b0001 << ctrl_addr_i[1:0];
        wdata_next = {4{ctrl_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        legal      = ~ctrl_addr_i[0];
        be_next    = 4'b0011 << {ctrl_addr_i[1], 1'b0};
        wdata_next = {2{ctrl_wdata_i[15:0]}};
      end
      SZ_WORD: begin
        legal      = (ctrl_addr_i[1:0] == 2'b00);
        be_next    = 4'b1111;
        wdata_next = ctrl_wdata_i;
      end
      default: legal = 1'b0;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend per captured size.
  always_comb begin
    rdata_shifted = data_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'b0, rdata_shifted[7:0]}
                                     : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_HALF: load_ext = unsigned_q ? {16'b0, rdata_shifted[15:0]}
                                     : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // Main sequencer. ctrl_ready_o mirrors state==IDLE, so accept is just
  // ctrl_valid_i while idle. Status pulses default low every cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state           <= ST_IDLE;
      ctrl_ready_o    <= 1'b1;
      ctrl_done_o     <= 1'b0;
      ctrl_misalign_o <= 1'b0;
      ctrl_err_o      <= 1'b0;
      ctrl_bad_addr_o <= '0;
      rf_we_o         <= 1'b0;
      rf_addr_o       <= '0;
      rf_data_o       <= '0;
      data_req_o      <= 1'b0;
      data_we_o       <= 1'b0;
      data_be_o       <= 4'b0000;
      data_addr_o     <= '0;
      data_wdata_o    <= '0;
      size_q          <= 2'b00;
      unsigned_q      <= 1'b0;
      addr_q          <= '0;
      rd_q            <= '0;
    end else begin
      ctrl_done_o     <= 1'b0;
      ctrl_misalign_o <= 1'b0;
      ctrl_err_o      <= 1'b0;
      rf_we_o         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ctrl_valid_i) begin
            if (legal) begin
              state        <= ST_REQ;
              ctrl_ready_o <= 1'b0;
              data_req_o   <= 1'b1;
              data_we_o    <= ctrl_we_i;
              data_be_o    <= be_next;
              data_addr_o  <= {ctrl_addr_i[ADDR_WIDTH-1:2], 2'b00};
              data_wdata_o <= wdata_next;
              size_q       <= ctrl_size_i;
              unsigned_q   <= ctrl_unsigned_i;
              addr_q       <= ctrl_addr_i;
              rd_q         <= ctrl_rd_i;
            end else begin
              ctrl_misalign_o <= 1'b1;
              ctrl_bad_addr_o <= ctrl_addr_i;
            end
          end
        end
        ST_REQ: begin
          if (data_gnt_i) begin
            state      <= ST_WAIT;
            data_req_o <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (data_rvalid_i) begin
            state        <= ST_IDLE;
            ctrl_ready_o <= 1'b1;
            if (data_err_i) begin
              ctrl_err_o      <= 1'b1;
              ctrl_bad_addr_o <= addr_q;
            end else begin
              ctrl_done_o <= 1'b1;
              // x0 is hardwired, so a load to rd=0 retires without a write.
              if (!data_we_o && (rd_q != '0)) begin
                rf_we_o   <= 1'b1;
                rf_addr_o <= rd_q;
                rf_data_o <= load_ext;
              end
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          ctrl_ready_o <= 1'b1;
          data_req_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb_jedro_1_lsu - directed self-checking bench for jedro_1_lsu.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_jedro_1_lsu;

  logic        clk;
  logic        rstn;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        ctrl_we;
  logic [1:0]  ctrl_size;
  logic        ctrl_unsigned;
  logic [31:0] ctrl_addr;
  logic [31:0] ctrl_wdata;
  logic [4:0]  ctrl_rd;
  logic        ctrl_done;
  logic        ctrl_misalign;
  logic        ctrl_err;
  logic [31:0] ctrl_bad_addr;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;

  int num_checks = 0;
  int num_fail   = 0;

  jedro_1_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready),
    .ctrl_we_i(ctrl_we), .ctrl_size_i(ctrl_size), .ctrl_unsigned_i(ctrl_unsigned),
    .ctrl_addr_i(ctrl_addr), .ctrl_wdata_i(ctrl_wdata), .ctrl_rd_i(ctrl_rd),
    .ctrl_done_o(ctrl_done), .ctrl_misalign_o(ctrl_misalign), .ctrl_err_o(ctrl_err),
    .ctrl_bad_addr_o(ctrl_bad_addr),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
    .data_wdata_o(data_wdata), .data_rdata_i(data_rdata), .data_err_i(data_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one op for a single cycle; it is accepted on that edge when idle.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd);
    ctrl_we       = we;
    ctrl_size     = size;
    ctrl_unsigned = uns;
    ctrl_addr     = addr;
    ctrl_wdata    = wdata;
    ctrl_rd       = rd;
    ctrl_valid    = 1'b1;
    tick();
    ctrl_valid    = 1'b0;
  endtask

  task automatic grant();
    data_gnt = 1'b1;
    tick();
    data_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err);
    data_rvalid = 1'b1;
    data_rdata  = rdata;
    data_err    = err;
    tick();
    data_rvalid = 1'b0;
    data_err    = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    ctrl_valid = 1'b0; ctrl_we = 1'b0; ctrl_size = 2'b00; ctrl_unsigned = 1'b0;
    ctrl_addr = '0; ctrl_wdata = '0; ctrl_rd = '0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0; data_err = 1'b0;
    tick();
    tick();
    checkOutput("reset_ready", 32'(ctrl_ready), 32'd1);
    checkOutput("reset_req", 32'(data_req), 32'd0);
    checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
    checkOutput("reset_done", 32'(ctrl_done), 32'd0);
    checkOutput("reset_bad_addr", ctrl_bad_addr, 32'h0);
    rstn = 1'b1;
    tick();

    // LW 0x100 -> x5, grant in the first request cycle, rvalid two cycles later.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
    checkOutput("lw_req", 32'(data_req), 32'd1);
    checkOutput("lw_ready_low", 32'(ctrl_ready), 32'd0);
    checkOutput("lw_be", 32'(data_be), 32'hF);
    checkOutput("lw_addr", data_addr, 32'h100);
    checkOutput("lw_we", 32'(data_we), 32'd0);
    grant();
    checkOutput("lw_req_drop", 32'(data_req), 32'd0);
    tick();
    respond(32'hDEADBEEF, 1'b0);
    checkOutput("lw_done", 32'(ctrl_done), 32'd1);
    checkOutput("lw_rf_we", 32'(rf_we), 32'd1);
    checkOutput("lw_rf_addr", 32'(rf_addr), 32'd5);
    checkOutput("lw_rf_data", rf_data, 32'hDEADBEEF);
    checkOutput("lw_ready_back", 32'(ctrl_ready), 32'd1);
    tick();
    checkOutput("lw_done_pulse", 32'(ctrl_done), 32'd0);
    checkOutput("lw_rf_we_pulse", 32'(rf_we), 32'd0);

    // LB 0x103 signed, then LBU from the same address.
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7);
    checkOutput("lb_be", 32'(data_be), 32'h8);
    checkOutput("lb_addr", data_addr, 32'h100);
    grant();
    respond(32'h80FF_0000, 1'b0);
    checkOutput("lb_rf_data", rf_data, 32'hFFFFFF80);
    checkOutput("lb_rf_addr", 32'(rf_addr), 32'd7);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd8);
    grant();
    respond(32'h80FF_0000, 1'b0);
    checkOutput("lbu_rf_data", rf_data, 32'h00000080);

    // LH 0x102 signed: upper half 0x8001 sign-extends.
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd9);
    checkOutput("lh_be", 32'(data_be), 32'hC);
    grant();
    respond(32'h8001_1234, 1'b0);
    checkOutput("lh_rf_data", rf_data, 32'hFFFF8001);

    // SH 0x102 with the grant held off for three cycles.
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 5'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sh_req_held", 32'(data_req), 32'd1);
      checkOutput("sh_be", 32'(data_be), 32'hC);
      checkOutput("sh_wdata", data_wdata, 32'hABCDABCD);
      checkOutput("sh_addr", data_addr, 32'h100);
      tick();
    end
    checkOutput("sh_req_4th", 32'(data_req), 32'd1);
    checkOutput("sh_we", 32'(data_we), 32'd1);
    grant();
    checkOutput("sh_req_drop", 32'(data_req), 32'd0);
    respond(32'h0, 1'b0);
    checkOutput("sh_done", 32'(ctrl_done), 32'd1);
    checkOutput("sh_no_rf_we", 32'(rf_we), 32'd0);

    // SB replicates the byte on every lane.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_005A, 5'd0);
    checkOutput("sb_be", 32'(data_be), 32'h2);
    checkOutput("sb_wdata", data_wdata, 32'h5A5A5A5A);
    grant();
    respond(32'h0, 1'b0);

    // Misaligned LW: no bus access, misalign pulse, still ready.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4);
    checkOutput("mis_pulse", 32'(ctrl_misalign), 32'd1);
    checkOutput("mis_no_req", 32'(data_req), 32'd0);
    checkOutput("mis_bad_addr", ctrl_bad_addr, 32'h101);
    checkOutput("mis_ready", 32'(ctrl_ready), 32'd1);
    tick();
    checkOutput("mis_pulse_end", 32'(ctrl_misalign), 32'd0);
    checkOutput("mis_no_req2", 32'(data_req), 32'd0);

    // Size 11 is illegal regardless of alignment.
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h300, 32'h0, 5'd4);
    checkOutput("illegal_size", 32'(ctrl_misalign), 32'd1);
    checkOutput("illegal_bad_addr", ctrl_bad_addr, 32'h300);

    // LH with a bus error response.
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h206, 32'h0, 5'd3);
    grant();
    respond(32'h12345678, 1'b1);
    checkOutput("err_pulse", 32'(ctrl_err), 32'd1);
    checkOutput("err_no_rf_we", 32'(rf_we), 32'd0);
    checkOutput("err_no_done", 32'(ctrl_done), 32'd0);
    checkOutput("err_bad_addr", ctrl_bad_addr, 32'h206);
    tick();
    checkOutput("err_pulse_end", 32'(ctrl_err), 32'd0);

    // Load to x0 retires without writeback; rvalid alongside gnt is ignored.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd0);
    data_rvalid = 1'b1;
    grant();
    data_rvalid = 1'b0;
    checkOutput("early_rvalid_no_done", 32'(ctrl_done), 32'd0);
    checkOutput("early_rvalid_busy", 32'(ctrl_ready), 32'd0);
    respond(32'hCAFEF00D, 1'b0);
    checkOutput("x0_done", 32'(ctrl_done), 32'd1);
    checkOutput("x0_no_rf_we", 32'(rf_we), 32'd0);

    // Reset while in REQ: request drops immediately, later rvalid ignored.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd6);
    checkOutput("rst_req_before", 32'(data_req), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("rst_req_drop", 32'(data_req), 32'd0);
    checkOutput("rst_ready", 32'(ctrl_ready), 32'd1);
    tick();
    rstn = 1'b1;
    respond(32'h11111111, 1'b0);
    checkOutput("rst_stray_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rst_stray_done", 32'(ctrl_done), 32'd0);

    // Reset while in WAIT.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd6);
    grant();
    rstn = 1'b0;
    #1;
    checkOutput("rstw_ready", 32'(ctrl_ready), 32'd1);
    tick();
    rstn = 1'b1;
    respond(32'h22222222, 1'b0);
    checkOutput("rstw_stray_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rstw_stray_done", 32'(ctrl_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
